// File: rtl/dm_wbuf_if.sv
// Handshake bundle between the memory-access stage, the write buffer and dm_4k.
// Ports: store request (st_*), load request/result (ld_*), data-memory port (dm_*),
//        occupancy status (count, empty). slave = buffer side, master = requester/memory side.
interface dm_wbuf_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_hit;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic          dm_wr;
  logic [DW-1:0] dm_dout;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, dm_dout,
    output st_ready, ld_data, ld_hit, dm_addr, dm_din, dm_wr, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, dm_dout,
    input  st_ready, ld_data, ld_hit, dm_addr, dm_din, dm_wr, count, empty
  );
endinterface

// File: rtl/dm_wbuf.sv
// Purpose: store queue in front of dm_4k with load forwarding from the newest matching store.
// Latency: store reaches dm_wr one cycle after push (empty queue, no load); loads complete combinationally.
// Backpressure: st_ready drops when DEPTH entries are held; loads always win the shared port and stall drain.
// Ports: clk, rst (async, active-high); bus (dm_wbuf_if.slave) carries st_*, ld_*, dm_*, count, empty.
module dm_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  dm_wbuf_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic          full;
  logic          push;
  logic          drain;
  logic          hit;
  logic [DW-1:0] fwd;
  logic [PW-1:0] idx;

  assign full  = (cnt == CW'(DEPTH));
  assign push  = bus.st_valid && !full;
  // A load owns the single memory port, so the head entry waits that cycle.
  assign drain = (cnt != '0) && !bus.ld_req;

  assign bus.count    = cnt;
  assign bus.empty    = (cnt == '0);
  assign bus.st_ready = !full;

  assign bus.dm_wr   = drain;
  assign bus.dm_addr = bus.ld_req ? bus.ld_addr : addr_q[head];
  assign bus.dm_din  = data_q[head];

  // Walk entries oldest to youngest so the last match seen is the newest store.
  // Only entries already held are searched; a same-cycle store is not visible.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < cnt) && (addr_q[idx] == bus.ld_addr)) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  assign bus.ld_hit  = hit;
  assign bus.ld_data = hit ? fwd : bus.dm_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= bus.st_addr;
        data_q[tail] <= bus.st_data;
        tail         <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(drain);
    end
  end
endmodule

// File: tb/tb_dm_wbuf.sv
module tb_dm_wbuf;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_wbuf_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
  dm_wbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural dm_4k: combinational read, write on rising edge.
  logic [DW-1:0] mem [32];
  int wr_cnt;
  assign bus.dm_dout = mem[bus.dm_addr];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    wr_cnt = 0;
    forever begin
      @(posedge clk);
      if (bus.dm_wr === 1'b1) begin
        mem[bus.dm_addr] <= bus.dm_din;
        wr_cnt++;
      end
    end
  end

  // Reference model: program-order queue of pending stores plus architectural memory.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic [DW-1:0] ref_mem [32];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lr, input logic [AW-1:0] la);
    @(negedge clk);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_req   = lr;
    bus.ld_addr  = la;
    #1;
  endtask

  task automatic advance();
    logic p, dr;
    ent_t e;
    p   = bus.st_valid && (q.size() < DEPTH);
    dr  = (q.size() > 0) && !bus.ld_req;
    e.a = bus.st_addr;
    e.d = bus.st_data;
    @(posedge clk);
    if (dr) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (p) q.push_back(e);
  endtask

  task automatic model_check();
    logic          hit;
    logic [DW-1:0] dat;
    logic          drn;
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("st_ready", bus.st_ready, q.size() != DEPTH);
    drn = (q.size() > 0) && !bus.ld_req;
    chk("dm_wr", bus.dm_wr, drn);
    if (bus.ld_req) begin
      chk("dm_addr_ld", bus.dm_addr, bus.ld_addr);
      hit = 1'b0;
      dat = ref_mem[bus.ld_addr];
      foreach (q[i]) if (q[i].a == bus.ld_addr) begin hit = 1'b1; dat = q[i].d; end
      chk("ld_hit", bus.ld_hit, hit);
      chk("ld_data", bus.ld_data, dat);
    end else if (drn) begin
      chk("dm_addr_drain", bus.dm_addr, q[0].a);
      chk("dm_din", bus.dm_din, q[0].d);
    end
  endtask

  typedef struct {
    logic sv; logic [AW-1:0] sa; logic [DW-1:0] sd; logic lr; logic [AW-1:0] la;
    logic rdy; logic [2:0] cnt; logic wr; logic [AW-1:0] addr; logic [DW-1:0] din;
    logic hit; logic [DW-1:0] dat;
  } vec_t;
  vec_t tbl[15];

  initial begin
    logic [DW-1:0] old [4];
    int w0;

    // Forwarding / fill / ordered drain, expectations worked out by hand.
    //            sv    sa    sd        lr    la    rdy   cnt   wr    addr  din       hit   dat
    tbl[0]  = '{1'b1, 5'd7, 32'hA,    1'b1, 5'd7, 1'b1, 3'd0, 1'b0, 5'd7, 32'h0,    1'b0, 32'h5A000007};
    tbl[1]  = '{1'b1, 5'd2, 32'hB,    1'b1, 5'd7, 1'b1, 3'd1, 1'b0, 5'd7, 32'h0,    1'b1, 32'hA};
    tbl[2]  = '{1'b1, 5'd7, 32'hC,    1'b1, 5'd2, 1'b1, 3'd2, 1'b0, 5'd2, 32'h0,    1'b1, 32'hB};
    tbl[3]  = '{1'b1, 5'd3, 32'hD,    1'b1, 5'd7, 1'b1, 3'd3, 1'b0, 5'd7, 32'h0,    1'b1, 32'hC};
    tbl[4]  = '{1'b1, 5'd5, 32'hE,    1'b1, 5'd9, 1'b0, 3'd4, 1'b0, 5'd9, 32'h0,    1'b0, 32'h5A000009};
    tbl[5]  = '{1'b1, 5'd5, 32'hE,    1'b1, 5'd3, 1'b0, 3'd4, 1'b0, 5'd3, 32'h0,    1'b1, 32'hD};
    tbl[6]  = '{1'b1, 5'd5, 32'hE,    1'b0, 5'd0, 1'b0, 3'd4, 1'b1, 5'd7, 32'hA,    1'b0, 32'h0};
    tbl[7]  = '{1'b1, 5'd5, 32'hE,    1'b0, 5'd0, 1'b1, 3'd3, 1'b1, 5'd2, 32'hB,    1'b0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 1'b1, 3'd3, 1'b0, 5'd5, 32'h0,    1'b1, 32'hE};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b1, 3'd3, 1'b0, 5'd7, 32'h0,    1'b1, 32'hC};
    tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 1'b1, 3'd3, 1'b0, 5'd2, 32'h0,    1'b0, 32'hB};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 3'd3, 1'b1, 5'd7, 32'hC,    1'b0, 32'h0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 3'd2, 1'b1, 5'd3, 32'hD,    1'b0, 32'h0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 3'd1, 1'b1, 5'd5, 32'hE,    1'b0, 32'h0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b1, 3'd0, 1'b0, 5'd7, 32'h0,    1'b0, 32'hC};

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h5A00_0000 | 32'(i);
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_req   = 1'b0; bus.ld_addr = '0;

    // Reset state while rst is held.
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ready", bus.st_ready, 1);
    chk("rst_dm_wr", bus.dm_wr, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_dm_din", bus.dm_din, 0);
    chk("rst_ld_hit", bus.ld_hit, 0);
    bus.ld_req = 1'b1; bus.ld_addr = 5'd13;
    #1;
    chk("rst_dm_addr_ld", bus.dm_addr, 13);
    bus.ld_req = 1'b0; bus.ld_addr = '0;
    @(negedge clk) rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lr, tbl[i].la);
      chk($sformatf("t%0d_ready", i), bus.st_ready, tbl[i].rdy);
      chk($sformatf("t%0d_count", i), bus.count, tbl[i].cnt);
      chk($sformatf("t%0d_dm_wr", i), bus.dm_wr, tbl[i].wr);
      chk($sformatf("t%0d_dm_addr", i), bus.dm_addr, tbl[i].addr);
      if (tbl[i].wr) chk($sformatf("t%0d_dm_din", i), bus.dm_din, tbl[i].din);
      if (tbl[i].lr) begin
        chk($sformatf("t%0d_ld_hit", i), bus.ld_hit, tbl[i].hit);
        chk($sformatf("t%0d_ld_data", i), bus.ld_data, tbl[i].dat);
      end
      advance();
    end

    // Single store latency.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("single_dm_wr", bus.dm_wr, 1);
    chk("single_dm_addr", bus.dm_addr, 5);
    chk("single_dm_din", bus.dm_din, 32'hDEADBEEF);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("single_mem5", mem[5], 32'hDEADBEEF);
    chk("single_empty", bus.empty, 1);
    advance();

    // Arbitration: loads hold off the queued entry.
    drive(1'b1, 5'd12, 32'h1234, 1'b1, 5'd12);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20);
    chk("arb1_dm_wr", bus.dm_wr, 0);
    chk("arb1_dm_addr", bus.dm_addr, 20);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd21);
    chk("arb2_dm_wr", bus.dm_wr, 0);
    chk("arb2_dm_addr", bus.dm_addr, 21);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("arb3_dm_wr", bus.dm_wr, 1);
    chk("arb3_dm_addr", bus.dm_addr, 12);
    chk("arb3_dm_din", bus.dm_din, 32'h1234);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("arb_mem12", mem[12], 32'h1234);
    advance();

    // Wrap-around: ten back-to-back stores, pointers lap the 4-entry ring twice.
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, AW'(i), 32'h100 + 32'(i), 1'b0, 5'd0);
      chk($sformatf("wrap%0d_count", i), bus.count, (i == 0) ? 0 : 1);
      advance();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("wrap_tail_count", bus.count, 1);
    advance();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("wrap_empty", bus.empty, 1);
    for (int i = 0; i < 10; i++) chk($sformatf("wrap_mem%0d", i), mem[i], 32'h100 + 32'(i));
    chk("wrap_writes", wr_cnt - w0, 10);
    advance();

    // Asynchronous reset with three stores queued.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, AW'(i), 32'h77 + 32'(i), 1'b1, 5'd0);
      advance();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int i = 1; i <= 3; i++) old[i] = ref_mem[i];
    w0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_ready", bus.st_ready, 1);
    chk("arst_dm_wr", bus.dm_wr, 0);
    chk("arst_empty", bus.empty, 1);
    #1 rst = 1'b0;
    q.delete();
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      advance();
    end
    for (int i = 1; i <= 3; i++) chk($sformatf("arst_mem%0d", i), mem[i], old[i]);
    chk("arst_writes", wr_cnt - w0, 0);

    // Randomized traffic against the queue model; load-heavy second half fills the buffer.
    for (int it = 0; it < 400; it++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < ((it < 200) ? 30 : 70), AW'($urandom_range(0, 9)));
      model_check();
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      model_check();
      advance();
    end
    for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
